// File: rtl/us_ping_scheduler_if.sv
// Sensor-side bundle of the ping scheduler: enable mask, pin read-back/drive and results.
// The scheduler sits on the slave modport; the system (or bench) drives the master side.
interface us_ping_scheduler_if #(
  parameter int N = 3
);
  logic [N-1:0]   ENABLE;
  logic [N-1:0]   SIG_IN;
  logic [N-1:0]   SIG_OUT;
  logic [N-1:0]   SIG_OE;
  logic [8*N-1:0] DIST;
  logic           VALID;
  logic [1:0]     ID;
  logic [N-1:0]   TIMEOUT;
  logic           BUSY;

  modport master (
    output ENABLE, SIG_IN,
    input  SIG_OUT, SIG_OE, DIST, VALID, ID, TIMEOUT, BUSY
  );

  modport slave (
    input  ENABLE, SIG_IN,
    output SIG_OUT, SIG_OE, DIST, VALID, ID, TIMEOUT, BUSY
  );
endinterface

// File: rtl/us_ping_scheduler.sv
// Round-robin trigger/echo sequencer for single-wire ultrasonic sensors.
// One sensor rings at a time; echo widths are converted to whole centimetres.
module us_ping_scheduler #(
  parameter int N           = 3,
  parameter int TRIG_CYCLES = 500,
  parameter int HOLDOFF_MAX = 80000,
  parameter int CM_CYCLES   = 5800,
  parameter int ECHO_MAX    = 1900000,
  parameter int GAP_CYCLES  = 20000
) (
  input  logic           CLK,
  input  logic           RST,
  us_ping_scheduler_if.slave bus
);

  localparam int MAX_AB  = (TRIG_CYCLES > HOLDOFF_MAX) ? TRIG_CYCLES : HOLDOFF_MAX;
  localparam int MAX_CD  = (ECHO_MAX > GAP_CYCLES) ? ECHO_MAX : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PS_W    = $clog2(CM_CYCLES + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_MAX - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CM_CYCLES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TRIG = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_MEAS = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [N-1:0]     sig_meta, sig_sync, sig_prev;
  logic [2:0]       state_q;
  logic [1:0]       id_q, last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PS_W-1:0]  presc_q;
  logic [7:0]       cm_q;
  logic [7:0]       dist_q [N];
  logic [N-1:0]     timeout_q;
  logic             valid_q;

  logic             sel_found;
  logic [1:0]       sel_idx;
  int               best_d, cand_d;
  logic             echo_now, echo_prev, rise, fall;
  logic [7:0]       cm_final;
  logic             done;
  logic [7:0]       done_dist;
  logic             done_to;
  logic [N-1:0]     oe_w;
  logic [8*N-1:0]   dist_w;

  // The pins are asynchronous; only the last stage feeds edge detection.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    sig_meta <= bus.SIG_IN;
    sig_sync <= sig_meta;
    sig_prev <= sig_sync;
  end

  // Pick the enabled sensor closest after last_q in round-robin order.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    best_d    = N;
    cand_d    = 0;
    for (int c = 0; c < N; c++) begin
      cand_d = (c + 2 * N - int'(last_q) - 1) % N;
      if (bus.ENABLE[c] && cand_d < best_d) begin
        best_d    = cand_d;
        sel_idx   = 2'(c);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    echo_now  = 1'b0;
    echo_prev = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (id_q == 2'(k)) begin
        echo_now  = sig_sync[k];
        echo_prev = sig_prev[k];
      end
    end
    rise = echo_now & ~echo_prev;
    fall = ~echo_now & echo_prev;
  end

  // The falling-edge cycle is itself an echo cycle, so it may complete a centimetre.
  assign cm_final = (presc_q == PS_LAST && cm_q != 8'hFF) ? cm_q + 8'd1 : cm_q;

  always_comb begin
    done      = 1'b0;
    done_dist = 8'hFF;
    done_to   = 1'b1;
    if (state_q == ST_WAIT && !rise && cnt_q == HOLD_LAST) begin
      done = 1'b1;
    end else if (state_q == ST_MEAS) begin
      if (fall) begin
        done      = 1'b1;
        done_dist = cm_final;
        done_to   = 1'b0;
      end else if (cnt_q == ECHO_LAST) begin
        done = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_q    <= 2'(N - 1);
      cnt_q     <= '0;
      presc_q   <= '0;
      cm_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= '0;
      // NOTE: the distance registers are reset explicitly because 8'hFF is the architected "no reading" value.
      for (int k = 0; k < N; k++) dist_q[k] <= 8'hFF;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            id_q    <= sel_idx;
            cnt_q   <= '0;
            state_q <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (rise) begin
            cnt_q   <= '0;
            presc_q <= '0;
            cm_q    <= '0;
            state_q <= ST_MEAS;
          end else if (!done) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_MEAS: begin
          if (!done) begin
            cnt_q <= cnt_q + 1'b1;
            if (presc_q == PS_LAST) begin
              presc_q <= '0;
              if (cm_q != 8'hFF) cm_q <= cm_q + 8'd1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            last_q  <= id_q;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (done) begin
        valid_q <= 1'b1;
        cnt_q   <= '0;
        state_q <= ST_GAP;
        for (int k = 0; k < N; k++) begin
          if (id_q == 2'(k)) begin
            dist_q[k]    <= done_dist;
            timeout_q[k] <= done_to;
          end
        end
      end
    end
  end

  always_comb begin
    oe_w   = '0;
    dist_w = '0;
    for (int k = 0; k < N; k++) begin
      oe_w[k]          = (state_q == ST_TRIG) && (id_q == 2'(k));
      dist_w[8*k +: 8] = dist_q[k];
    end
  end

  assign bus.SIG_OE  = oe_w;
  assign bus.SIG_OUT = oe_w;
  assign bus.DIST    = dist_w;
  assign bus.VALID   = valid_q;
  assign bus.ID      = id_q;
  assign bus.TIMEOUT = timeout_q;
  assign bus.BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Directed bench for us_ping_scheduler: per-transaction vector table plus
// hand sequences for idle-with-no-enables, mid-measure reset and line glitches.
module tb_us_ping_scheduler;

  localparam int N = 3;

  typedef struct {
    logic [2:0] en;
    int         dly;
    int         width;
    logic [1:0] exp_id;
    logic [7:0] exp_dist;
    logic       exp_to;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  us_ping_scheduler_if #(.N(N)) bus ();

  us_ping_scheduler #(
    .N(N), .TRIG_CYCLES(5), .HOLDOFF_MAX(50), .CM_CYCLES(10),
    .ECHO_MAX(3000), .GAP_CYCLES(20)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle counter and pin-drive monitor.
  int         cyc = 0;
  int         t_end = 0;
  int         trig_len = 0;
  bit         bad_oe = 1'b0;
  logic [2:0] mon_oe_prev = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.SIG_OE != 3'b000) begin
      if (mon_oe_prev == 3'b000) trig_len = 1;
      else trig_len++;
      if (bus.SIG_OE != (3'b001 << bus.ID)) bad_oe = 1'b1;
    end
    if (bus.SIG_OUT !== bus.SIG_OE) bad_oe = 1'b1;
    if (mon_oe_prev != 3'b000 && bus.SIG_OE == 3'b000) t_end = cyc;
    mon_oe_prev = bus.SIG_OE;
  end

  // Sensor model: after the trigger falls, wait cfg_dly cycles, then echo high cfg_w cycles.
  int         cfg_dly = 0;
  int         cfg_w   = 0;
  logic [2:0] glitch  = '0;
  logic [2:0] drive   = '0;
  logic [2:0] mdl_oe_prev = '0;
  int         dly_c [N];
  int         w_c   [N];
  bit         armed [N];

  initial begin
    for (int k = 0; k < N; k++) begin
      dly_c[k] = 0; w_c[k] = 0; armed[k] = 1'b0;
    end
    bus.SIG_IN = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (mdl_oe_prev[k] && !bus.SIG_OE[k] && cfg_w > 0) begin
          dly_c[k] = cfg_dly;
          w_c[k]   = cfg_w;
          armed[k] = 1'b1;
        end
        if (armed[k]) begin
          if (dly_c[k] > 0) dly_c[k]--;
          else if (w_c[k] > 0) begin
            drive[k] = 1'b1;
            w_c[k]--;
          end else begin
            drive[k] = 1'b0;
            armed[k] = 1'b0;
          end
        end
      end
      mdl_oe_prev = bus.SIG_OE;
      bus.SIG_IN  = drive | glitch;
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (bus.VALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe(input bit level, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ((bus.SIG_OE != 3'b000) == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       vecs [11];
  logic [7:0] exp_d [N];
  logic [2:0] exp_to;
  bit         ok;
  int         n_valid;
  bit         quiet;

  initial begin
    vecs[0]  = '{3'b111, 10,  200, 2'd0, 8'd20,  1'b0, -1};
    vecs[1]  = '{3'b111, 10,    0, 2'd1, 8'hFF,  1'b1, 50};
    vecs[2]  = '{3'b111, 10, 2800, 2'd2, 8'hFF,  1'b0, -1};
    vecs[3]  = '{3'b111, 10, 3100, 2'd0, 8'hFF,  1'b1, -1};
    vecs[4]  = '{3'b111, 10,   57, 2'd1, 8'd5,   1'b0, -1};
    vecs[5]  = '{3'b101, 10,    9, 2'd2, 8'd0,   1'b0, -1};
    vecs[6]  = '{3'b101, 10,   10, 2'd0, 8'd1,   1'b0, -1};
    vecs[7]  = '{3'b101, 10,   19, 2'd2, 8'd1,   1'b0, -1};
    vecs[8]  = '{3'b101, 10,   30, 2'd0, 8'd3,   1'b0, -1};
    vecs[9]  = '{3'b010, 10,   40, 2'd1, 8'd4,   1'b0, -1};
    vecs[10] = '{3'b010, 10,   41, 2'd1, 8'd4,   1'b0, -1};
    for (int k = 0; k < N; k++) exp_d[k] = 8'hFF;
    exp_to = '0;

    bus.ENABLE = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_oe",      32'(bus.SIG_OE),  32'h0);
    check("rst_out",     32'(bus.SIG_OUT), 32'h0);
    check("rst_dist",    32'(bus.DIST),    32'hFFFFFF);
    check("rst_valid",   32'(bus.VALID),   32'h0);
    check("rst_id",      32'(bus.ID),      32'h0);
    check("rst_timeout", 32'(bus.TIMEOUT), 32'h0);
    check("rst_busy",    32'(bus.BUSY),    32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      bus.ENABLE = vecs[i].en;
      cfg_dly    = vecs[i].dly;
      cfg_w      = vecs[i].width;
      bad_oe     = 1'b0;
      wait_valid(ok);
      check($sformatf("v%0d_valid_seen", i), 32'(ok), 32'h1);
      if (ok) begin
        exp_d[vecs[i].exp_id]  = vecs[i].exp_dist;
        exp_to[vecs[i].exp_id] = vecs[i].exp_to;
        check($sformatf("v%0d_id", i),       32'(bus.ID),      32'(vecs[i].exp_id));
        check($sformatf("v%0d_dist", i),     32'(bus.DIST),    32'({exp_d[2], exp_d[1], exp_d[0]}));
        check($sformatf("v%0d_timeout", i),  32'(bus.TIMEOUT), 32'(exp_to));
        check($sformatf("v%0d_trig_len", i), 32'(trig_len),    32'd5);
        check($sformatf("v%0d_oe_clean", i), 32'(bad_oe),      32'h0);
        if (vecs[i].exp_lat >= 0)
          check($sformatf("v%0d_latency", i), 32'(cyc - t_end), 32'(vecs[i].exp_lat));
      end
    end

    // No enables: the block must stay idle and never drive a pin.
    bus.ENABLE = 3'b000;
    repeat (30) @(negedge clk);
    quiet = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.BUSY || bus.SIG_OE != 3'b000) quiet = 1'b0;
    end
    check("idle_no_enable_quiet", 32'(quiet), 32'h1);

    // Reset in the middle of a measurement on sensor 2.
    bus.ENABLE = 3'b111;
    cfg_dly    = 5;
    cfg_w      = 500;
    wait_oe(1'b1, ok);
    check("pre_rst_trig_sensor", 32'(bus.SIG_OE), 32'h4);
    wait_oe(1'b0, ok);
    repeat (25) @(negedge clk);
    check("pre_rst_busy", 32'(bus.BUSY), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_oe",      32'(bus.SIG_OE),  32'h0);
    check("mid_rst_dist",    32'(bus.DIST),    32'hFFFFFF);
    check("mid_rst_timeout", 32'(bus.TIMEOUT), 32'h0);
    check("mid_rst_busy",    32'(bus.BUSY),    32'h0);
    for (int k = 0; k < N; k++) exp_d[k] = 8'hFF;
    exp_to = '0;
    cfg_w  = 123;
    rst    = 1'b0;
    wait_oe(1'b1, ok);
    check("post_rst_first_sensor", 32'(bus.SIG_OE), 32'h1);

    // Glitch the non-selected lines while sensor 0 measures.
    wait_oe(1'b0, ok);
    repeat (12) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      @(posedge clk); #1 glitch = 3'b110;
      @(posedge clk); #1 glitch = 3'b000;
      repeat (6) @(posedge clk);
    end
    wait_valid(ok);
    check("glitch_valid_seen", 32'(ok), 32'h1);
    check("glitch_id",   32'(bus.ID),   32'h0);
    check("glitch_dist", 32'(bus.DIST), 32'hFFFF0C);
    check("glitch_timeout", 32'(bus.TIMEOUT), 32'h0);
    n_valid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.VALID) n_valid++;
    end
    check("single_valid", 32'(n_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
